// File: rtl/cam_frame_writer_if.sv
// rtl/cam_frame_writer_if.sv - frame buffer write port between capture stage and buffer
// Purpose: bundles the buffer write strobe, address and pixel data.
// Ports (signals):
//   w_en   - one-cycle write strobe per captured pixel
//   w_addr - linear buffer address, ADDR_W bits
//   w_data - 16-bit pixel value
// Modports: master (capture stage drives), slave (frame buffer receives).
interface cam_frame_writer_if #(
  parameter int ADDR_W = 16
);
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       w_data;

  modport master (output w_en, output w_addr, output w_data);
  modport slave  (input  w_en, input  w_addr, input  w_data);
endinterface

// File: rtl/cam_frame_writer.sv
// rtl/cam_frame_writer.sv - OV7670 capture stage: byte pairing, x/y tracking, window crop, buffer writes
// Purpose: assembles RGB565 pixels from the camera byte stream, crops a
// WIN_W x WIN_H window at (X_OFF, Y_OFF) and writes it linearly into the
// frame buffer; reports frame ends and honours a per-frame freeze.
// Optional feature: define CAPTURE_GRAY_EN to write 8-bit luma instead of
// RGB565 (one extra pipeline stage on the write port).
// Ports:
//   clk, rst       - PCLK and asynchronous active-high reset
//   vsync, href    - camera frame / line sync
//   data           - camera D7..D0
//   freeze         - sampled at frame start; suppresses writes for that frame
//   wr             - buffer write port (w_en, w_addr, w_data)
//   frame_done     - one-cycle pulse at the end of a captured frame
//   frame_written  - last completed frame was written (not frozen)
//   pix_x, pix_y   - current camera column / line
//   err_odd        - sticky: a line ended on an odd byte count
module cam_frame_writer #(
  parameter int WIN_W  = 256,
  parameter int WIN_H  = 256,
  parameter int X_OFF  = 0,
  parameter int Y_OFF  = 0,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vsync,
  input  logic                href,
  input  logic [7:0]          data,
  input  logic                freeze,
  cam_frame_writer_if.master  wr,
  output logic                frame_done,
  output logic                frame_written,
  output logic [9:0]          pix_x,
  output logic [8:0]          pix_y,
  output logic                err_odd
);

  localparam int SHIFT = $clog2(WIN_W);

  typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE} state_t;

  state_t            state, state_next;
  logic              vsync_q, href_q;
  logic              phase, skip;
  logic [7:0]        hi_byte;
  logic              vs_rise, vs_fall, href_fall;
  logic              pix_strobe, in_win, wr_fire;
  logic [15:0]       pixel;
  logic [ADDR_W-1:0] addr_calc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    vs_rise    = vsync & ~vsync_q;
    vs_fall    = ~vsync & vsync_q;
    href_fall  = ~href & href_q;
    pix_strobe = 1'b0;
    case (state)
      SYNC:    if (vsync) state_next = VBLANK;
      VBLANK:  if (vs_fall) state_next = ACTIVE;
      ACTIVE: begin
        // A rising vsync abandons any byte sampled in the same cycle.
        if (vs_rise) state_next = VBLANK;
        else         pix_strobe = href & phase;
      end
      default: state_next = SYNC;
    endcase
  end

  always_comb begin
    in_win = ({22'd0, pix_x} >= 32'(X_OFF)) && ({22'd0, pix_x} < 32'(X_OFF + WIN_W)) &&
             ({23'd0, pix_y} >= 32'(Y_OFF)) && ({23'd0, pix_y} < 32'(Y_OFF + WIN_H));
    addr_calc = ADDR_W'((({23'd0, pix_y} - 32'(Y_OFF)) << SHIFT) + ({22'd0, pix_x} - 32'(X_OFF)));
    pixel     = {hi_byte, data};
    wr_fire   = pix_strobe & in_win & ~skip;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      phase         <= 1'b0;
      skip          <= 1'b0;
      hi_byte       <= 8'd0;
      pix_x         <= 10'd0;
      pix_y         <= 9'd0;
      frame_done    <= 1'b0;
      frame_written <= 1'b0;
      err_odd       <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      href_q     <= href;
      frame_done <= 1'b0;
      case (state)
        VBLANK: begin
          if (vs_fall) begin
            pix_x <= 10'd0;
            pix_y <= 9'd0;
            skip  <= freeze;
            phase <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            frame_done    <= 1'b1;
            frame_written <= ~skip;
            phase         <= 1'b0;
          end else if (href) begin
            phase <= ~phase;
            if (!phase) hi_byte <= data;
            else if (pix_x != 10'h3FF) pix_x <= pix_x + 10'd1;
          end else if (href_fall) begin
            pix_x <= 10'd0;
            if (pix_y != 9'h1FF) pix_y <= pix_y + 9'd1;
            // Dangling high byte: drop it so the next line stays pixel-aligned.
            if (phase) begin
              err_odd <= 1'b1;
              phase   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CAPTURE_GRAY_EN
  logic              s1_en;
  logic [ADDR_W-1:0] s1_addr;
  logic [15:0]       s1_pix;
  logic [15:0]       luma_sum;

  // Weights sum to 256, so the top byte of the weighted sum is the luma.
  always_comb begin
    luma_sum = 16'd77  * {8'd0, s1_pix[15:11], 3'b000} +
               16'd150 * {8'd0, s1_pix[10:5],  2'b00}  +
               16'd29  * {8'd0, s1_pix[4:0],   3'b000};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_en     <= 1'b0;
      s1_addr   <= '0;
      s1_pix    <= 16'd0;
      wr.w_en   <= 1'b0;
      wr.w_addr <= '0;
      wr.w_data <= 16'd0;
    end else begin
      s1_en   <= wr_fire;
      wr.w_en <= s1_en;
      if (wr_fire) begin
        s1_addr <= addr_calc;
        s1_pix  <= pixel;
      end
      if (s1_en) begin
        wr.w_addr <= s1_addr;
        wr.w_data <= {8'h00, 8'(luma_sum >> 8)};
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr.w_en   <= 1'b0;
      wr.w_addr <= '0;
      wr.w_data <= 16'd0;
    end else begin
      wr.w_en <= wr_fire;
      if (wr_fire) begin
        wr.w_addr <= addr_calc;
        wr.w_data <= pixel;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb/tb_cam_frame_writer.sv - self-checking bench for cam_frame_writer with a pixel-level reference model
module tb_cam_frame_writer;
  localparam int WIN_W  = 16;
  localparam int WIN_H  = 8;
  localparam int X_OFF  = 3;
  localparam int Y_OFF  = 2;
  localparam int ADDR_W = 7;
`ifdef CAPTURE_GRAY_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic       freeze = 1'b0;
  logic [7:0] data = 8'd0;
  logic       frame_done, frame_written, err_odd;
  logic [9:0] pix_x;
  logic [8:0] pix_y;

  cam_frame_writer_if #(.ADDR_W(ADDR_W)) wr ();

  cam_frame_writer #(
    .WIN_W(WIN_W), .WIN_H(WIN_H), .X_OFF(X_OFF), .Y_OFF(Y_OFF), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .data(data), .freeze(freeze),
    .wr(wr), .frame_done(frame_done), .frame_written(frame_written),
    .pix_x(pix_x), .pix_y(pix_y), .err_odd(err_odd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int a; int d; } wr_t;
  wr_t obs_q[$];
  wr_t exp_q[$];

  always @(negedge clk) begin
    if (wr.w_en === 1'b1) obs_q.push_back('{c: cyc, a: int'(wr.w_addr), d: int'(wr.w_data)});
  end

  int checks = 0;
  int errors = 0;
  bit exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic [7:0] d);
    vsync = v;
    href  = h;
    data  = d;
    @(negedge clk);
  endtask

  // Expected buffer contents for a camera pixel, straight from the pixel formats.
  function automatic int expect_pix(input logic [15:0] p);
`ifdef CAPTURE_GRAY_EN
    int r, g, b;
    r = int'(p[15:11]) * 8;
    g = int'(p[10:5]) * 4;
    b = int'(p[4:0]) * 8;
    return (77 * r + 150 * g + 29 * b) / 256;
`else
    return int'(p);
`endif
  endfunction

  task automatic compare_writes();
    int n;
    chk("write_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("w_addr", obs_q[i].a, exp_q[i].a);
      chk("w_data", obs_q[i].d, exp_q[i].d);
      chk("w_cycle", obs_q[i].c, exp_q[i].c);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input bit fz, input bit fz_mid, input int nlines,
                           input bit odd_en, input bit abort_end);
    int npix, c;
    logic [7:0] hi, lo;
    freeze = fz;
    step(1, 0, 8'($urandom));
    step(1, 1, 8'($urandom));
    step(1, 1, 8'($urandom));
    step(1, 0, 8'($urandom));
    step(0, 0, 8'($urandom));
    freeze = fz_mid;
    step(0, 0, 8'($urandom));
    for (int y = 0; y < nlines; y++) begin
      npix = (y == 2) ? 5 : int'($urandom_range(30, 20));
      for (int j = 0; j < npix; j++) begin
        hi = 8'($urandom);
        lo = 8'($urandom);
        step(0, 1, hi);
        c = cyc;
        step(0, 1, lo);
        if (!fz && j >= X_OFF && j < X_OFF + WIN_W && y >= Y_OFF && y < Y_OFF + WIN_H)
          exp_q.push_back('{c: c + LAT, a: (y - Y_OFF) * WIN_W + (j - X_OFF), d: expect_pix({hi, lo})});
      end
      chk("pix_x_eol", pix_x, npix);
      if (abort_end && y == nlines - 1) begin
        step(0, 1, 8'($urandom));
      end else begin
        if (odd_en && y == 3) begin
          step(0, 1, 8'($urandom));
          exp_err = 1'b1;
        end
        step(0, 0, 8'd0);
        step(0, 0, 8'd0);
        step(0, 0, 8'd0);
      end
    end
    step(1, abort_end, 8'($urandom));
    chk("frame_done_pulse", frame_done, 1);
    chk("frame_written", frame_written, !fz);
    chk("pix_y_eof", pix_y, abort_end ? nlines - 1 : nlines);
    chk("err_odd", err_odd, exp_err);
    step(1, 0, 8'd0);
    chk("frame_done_one_cycle", frame_done, 0);
    compare_writes();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    step(0, 1, 8'h12);
    chk("rst_w_en", wr.w_en, 0);
    chk("rst_w_addr", wr.w_addr, 0);
    chk("rst_w_data", wr.w_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_written", frame_written, 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_err_odd", err_odd, 0);

    // Reset released mid-line with vsync low: nothing may be written.
    step(0, 1, 8'h34);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step(0, 1, 8'($urandom));
    step(0, 0, 8'd0);
    step(0, 0, 8'd0);
    for (int i = 0; i < 40; i++) step(0, 1, 8'($urandom));
    step(0, 0, 8'd0);
    step(0, 0, 8'd0);
    chk("no_write_before_vsync", obs_q.size(), 0);
    chk("sync_pix_y", pix_y, 0);

    run_frame(1'b0, 1'b1, 12, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 11, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 12, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, 13, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      run_frame(1'(($urandom_range(3, 0) == 0)), 1'($urandom), int'($urandom_range(14, 10)), 1'b0, 1'($urandom));

    // Asynchronous reset while a write strobe is high.
    freeze = 1'b0;
    step(1, 0, 8'd0);
    step(1, 0, 8'd0);
    step(0, 0, 8'd0);
    step(0, 0, 8'd0);
    for (int y = 0; y < 3; y++) begin
      for (int j = 0; j < 10; j++) begin
        step(0, 1, 8'($urandom));
        step(0, 1, 8'($urandom));
        if (y == 2 && j == 4) break;
      end
      if (y < 2) begin
        step(0, 0, 8'd0);
        step(0, 0, 8'd0);
      end
    end
    chk("w_en_before_reset", wr.w_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_w_en", wr.w_en, 0);
    chk("async_rst_err_odd", err_odd, 0);
    chk("async_rst_frame_written", frame_written, 0);
    chk("async_rst_pix_x", pix_x, 0);
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    step(0, 0, 8'd0);

    run_frame(1'b0, 1'b0, 11, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
